// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial memory-link arbiter: FSM encodings,
// header bit layout and digit-count helpers.
package serial_bus_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_WDATA = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_RDATA = 3'd5;

    // Header digit: start marker above the write flag, rest zero.
    localparam int HDR_START_BIT = 1;
    localparam int HDR_WRITE_BIT = 0;

    localparam int DEF_A = 16 / 2;
    localparam int DEF_D = 16 / 2;

    function automatic int num_digits(input int bits, input int io);
        return bits / io;
    endfunction

    function automatic int cnt_width(input int a, input int d);
        int m;
        m = (a > d) ? a : d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bus_serdes.sv
// Shift register with parallel load, LSB-first digit shift-out and
// MSB-side digit shift-in; shared by the address and data phases.
module bus_serdes #(
    parameter int WIDTH   = 16,
    parameter int IO_BITS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               shift_out,
    input  logic               shift_in,
    input  logic [IO_BITS-1:0] din,
    output logic [IO_BITS-1:0] dout,
    output logic [WIDTH-1:0]   q
);

    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (shift_out)
            q <= {{IO_BITS{1'b0}}, q[WIDTH-1:IO_BITS]};
        else if (shift_in)
            q <= {din, q[WIDTH-1:IO_BITS]};
    end

    assign dout = q[IO_BITS-1:0];

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin sharing of the narrow serial memory link between the CPU port
// and the loader/debug port; serializes header/address/wdata, deserializes reads.
module serial_bus_arbiter
    import serial_bus_pkg::*;
#(
    parameter int IO_BITS   = 2,
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_write,
    input  logic [2*ADDR_BITS-1:0] req_addr,
    input  logic [2*DATA_BITS-1:0] req_wdata,
    output logic [1:0]             req_ready,
    output logic                   resp_valid,
    output logic                   resp_id,
    output logic [DATA_BITS-1:0]   resp_rdata,
    output logic                   resp_err,
    output logic [IO_BITS-1:0]     tx_pins,
    input  logic [IO_BITS-1:0]     rx_pins,
    output logic                   busy
);

    localparam int A  = num_digits(ADDR_BITS, IO_BITS);
    localparam int D  = num_digits(DATA_BITS, IO_BITS);
    localparam int CW = cnt_width(A, D);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] A_LAST = CW'(A - 1);
    localparam logic [CW-1:0] D_LAST = CW'(D - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [TW-1:0]        tcnt;
    logic                 last_grant, cur_write, cur_id;
    logic                 winner, accept;
    logic [IO_BITS-1:0]   hdr, addr_digit, data_digit;
    logic [DATA_BITS-1:0] data_q, rdata_next;
    logic [ADDR_BITS-1:0] unused_addr_q;
    logic [IO_BITS-1:0]   unused_data_dout;
    logic                 addr_shift, data_shift_out, data_shift_in;

    always_comb begin
        // On a tie, the requester that did not win last time goes first.
        winner    = (&req_valid) ? ~last_grant : req_valid[1];
        accept    = (state == ST_IDLE) && (|req_valid);
        req_ready = '0;
        if (accept)
            req_ready[winner] = 1'b1;
        hdr                = '0;
        hdr[HDR_START_BIT] = 1'b1;
        hdr[HDR_WRITE_BIT] = req_write[winner];
    end

    // tx_pins is loaded one cycle ahead, so the serdes shifts while the
    // previous digit is on the pins.
    assign addr_shift     = (state == ST_HDR) || (state == ST_ADDR);
    assign data_shift_out = (state == ST_WDATA) ||
                            ((state == ST_ADDR) && (cnt == A_LAST) && cur_write);
    assign data_shift_in  = (state == ST_RDATA);
    assign data_digit     = data_q[IO_BITS-1:0];
    assign rdata_next     = {rx_pins, data_q[DATA_BITS-1:IO_BITS]};
    assign busy           = (state != ST_IDLE);

    bus_serdes #(.WIDTH(ADDR_BITS), .IO_BITS(IO_BITS)) u_addr_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (req_addr[winner*ADDR_BITS +: ADDR_BITS]),
        .shift_out(addr_shift),
        .shift_in (1'b0),
        .din      ('0),
        .dout     (addr_digit),
        .q        (unused_addr_q)
    );

    bus_serdes #(.WIDTH(DATA_BITS), .IO_BITS(IO_BITS)) u_data_sr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (req_wdata[winner*DATA_BITS +: DATA_BITS]),
        .shift_out(data_shift_out),
        .shift_in (data_shift_in),
        .din      (rx_pins),
        .dout     (unused_data_dout),
        .q        (data_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            tcnt       <= '0;
            last_grant <= 1'b1;
            cur_write  <= 1'b0;
            cur_id     <= 1'b0;
            tx_pins    <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_HDR;
                        cur_write  <= req_write[winner];
                        cur_id     <= winner;
                        last_grant <= winner;
                        tx_pins    <= hdr;
                        cnt        <= '0;
                        tcnt       <= '0;
                    end
                end
                ST_HDR: begin
                    state   <= ST_ADDR;
                    tx_pins <= addr_digit;
                end
                ST_ADDR: begin
                    if (cnt == A_LAST) begin
                        cnt <= '0;
                        if (cur_write) begin
                            state   <= ST_WDATA;
                            tx_pins <= data_digit;
                        end else begin
                            state   <= ST_WAIT;
                            tx_pins <= '0;
                        end
                    end else begin
                        cnt     <= cnt + CW'(1);
                        tx_pins <= addr_digit;
                    end
                end
                ST_WDATA: begin
                    if (cnt == D_LAST) begin
                        cnt        <= '0;
                        state      <= ST_IDLE;
                        tx_pins    <= '0;
                        resp_valid <= 1'b1;
                        resp_id    <= cur_id;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        tx_pins <= data_digit;
                    end
                end
                ST_WAIT: begin
                    if (rx_pins[0]) begin
                        state <= ST_RDATA;
                    end else if (tcnt == T_LAST) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b1;
                        resp_id    <= cur_id;
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_RDATA: begin
                    if (cnt == D_LAST) begin
                        cnt        <= '0;
                        state      <= ST_IDLE;
                        resp_valid <= 1'b1;
                        resp_id    <= cur_id;
                        resp_rdata <= rdata_next;
                        resp_err   <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed-vector bench for serial_bus_arbiter at default parameters.
module tb_serial_bus_arbiter;

    localparam int IO_BITS   = 2;
    localparam int ADDR_BITS = 16;
    localparam int DATA_BITS = 16;
    localparam int TIMEOUT   = 64;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [1:0]             req_valid, req_write, req_ready;
    logic [2*ADDR_BITS-1:0] req_addr;
    logic [2*DATA_BITS-1:0] req_wdata;
    logic                   resp_valid, resp_id, resp_err, busy;
    logic [DATA_BITS-1:0]   resp_rdata;
    logic [IO_BITS-1:0]     tx_pins, rx_pins;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] wr_dig [16] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0,
                                2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2};
    logic [1:0] ra_dig [8]  = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [1:0] rd_dig [8]  = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
    logic [1:0] rr_grant [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic       rr_prev_id [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    serial_bus_arbiter #(
        .IO_BITS(IO_BITS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_id   (resp_id),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .tx_pins   (tx_pins),
        .rx_pins   (rx_pins),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        rx_pins   = '0;
        tick();
        tick();
        settle();
        chk("rst_tx", tx_pins, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // requester 0 write 0x1234 <- 0xBEEF
        req_valid = 2'b01; req_write = 2'b01;
        req_addr[15:0] = 16'h1234; req_wdata[15:0] = 16'hBEEF;
        settle();
        chk("wr_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        settle();
        chk("wr_hdr", tx_pins, 2'b11);
        chk("wr_busy", busy, 1);
        chk("wr_no_ready", req_ready, 0);
        for (int c = 0; c < 16; c++) begin
            tick();
            settle();
            chk($sformatf("wr_dig%0d", c), tx_pins, wr_dig[c]);
            chk($sformatf("wr_idle_resp%0d", c), resp_valid, 0);
        end
        tick();
        settle();
        chk("wr_resp_valid", resp_valid, 1);
        chk("wr_resp_id", resp_id, 0);
        chk("wr_resp_err", resp_err, 0);
        chk("wr_resp_rdata", resp_rdata, 0);
        chk("wr_tx_idle", tx_pins, 0);
        chk("wr_busy_done", busy, 0);

        // requester 1 read 0x00FF, start digit at WAIT cycle 3, data 0xA5C3
        tick();
        req_valid = 2'b10; req_write = 2'b00; req_addr[31:16] = 16'h00FF;
        settle();
        chk("rd_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        settle();
        chk("rd_hdr", tx_pins, 2'b10);
        for (int c = 0; c < 8; c++) begin
            tick();
            settle();
            chk($sformatf("rd_addr%0d", c), tx_pins, ra_dig[c]);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            settle();
            chk($sformatf("rd_wait_tx%0d", c), tx_pins, 0);
            chk($sformatf("rd_wait_resp%0d", c), resp_valid, 0);
        end
        tick();
        rx_pins = 2'b01;
        for (int c = 0; c < 8; c++) begin
            tick();
            rx_pins = rd_dig[c];
            settle();
            chk($sformatf("rd_shift_resp%0d", c), resp_valid, 0);
        end
        tick();
        rx_pins = 2'b00;
        settle();
        chk("rd_resp_valid", resp_valid, 1);
        chk("rd_rdata", resp_rdata, 16'hA5C3);
        chk("rd_resp_id", resp_id, 1);
        chk("rd_resp_err", resp_err, 0);

        // read with rx held low: error response TIMEOUT cycles into WAIT
        tick();
        req_valid = 2'b01; req_write = 2'b00; req_addr[15:0] = 16'h0042;
        settle();
        chk("to_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        for (int c = 1; c < 2 + 8 + TIMEOUT; c++) begin
            settle();
            chk($sformatf("to_wait%0d", c), resp_valid, 0);
            tick();
        end
        settle();
        chk("to_resp_valid", resp_valid, 1);
        chk("to_resp_err", resp_err, 1);
        chk("to_rdata", resp_rdata, 0);
        chk("to_resp_id", resp_id, 0);
        chk("to_busy", busy, 0);

        // both requesters continuously valid: grants alternate from 0
        tick();
        do_reset();
        req_valid = 2'b11; req_write = 2'b11;
        req_addr  = {16'hAAAA, 16'h5555};
        req_wdata = {16'h0F0F, 16'hF0F0};
        for (int g = 0; g < 4; g++) begin
            settle();
            chk($sformatf("rr_grant%0d", g), req_ready, rr_grant[g]);
            if (g > 0) begin
                chk($sformatf("rr_resp_valid%0d", g), resp_valid, 1);
                chk($sformatf("rr_resp_id%0d", g), resp_id, rr_prev_id[g]);
            end
            for (int c = 1; c < 18; c++) begin
                tick();
                if (c == 8) begin
                    settle();
                    chk($sformatf("rr_no_ready%0d", g), req_ready, 0);
                end
            end
            settle();
            chk($sformatf("rr_pre_resp%0d", g), resp_valid, 0);
            tick();
        end
        req_valid = 2'b00;
        settle();
        chk("rr_last_resp", resp_valid, 1);
        chk("rr_last_id", resp_id, 1);

        // reset during the address phase of a write
        tick();
        req_valid = 2'b01; req_write = 2'b01;
        req_addr[15:0] = 16'hFFFF; req_wdata[15:0] = 16'h1357;
        settle();
        chk("rs_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        reset = 1'b1;
        settle();
        chk("rs_busy_addr", busy, 1);
        chk("rs_tx_addr", tx_pins, 2'b11);
        tick();
        reset = 1'b0;
        settle();
        chk("rs_tx", tx_pins, 0);
        chk("rs_busy", busy, 0);
        chk("rs_resp", resp_valid, 0);
        req_valid = 2'b11;
        settle();
        chk("rs_tie", req_ready, 2'b01);
        req_valid = 2'b10;
        settle();
        chk("rs_only1", req_ready, 2'b10);
        req_valid = 2'b00;
        for (int c = 0; c < 20; c++) begin
            tick();
            settle();
            chk($sformatf("rs_quiet_resp%0d", c), resp_valid, 0);
            chk($sformatf("rs_quiet_busy%0d", c), busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_bus_arbiter.md
# serial_bus_arbiter

Shares the CPU core's narrow serial memory link (IO_BITS-wide `tx_pins`/`rx_pins`) between two parallel requesters: the CPU fetch/load-store port and a loader/debug port. It grants one requester at a time with round-robin arbitration. For each granted transaction it serializes a header, an address and optional write data onto `tx_pins`. For reads it deserializes the response from `rx_pins`, with a timeout. It sits between the core-side request logic and the top-level pin registers.

## Interface
Parameters:
- IO_BITS, 2, serial digit width
- ADDR_BITS, 16, address width; must be a multiple of IO_BITS
- DATA_BITS, 16, data width; must be a multiple of IO_BITS
- TIMEOUT, 64, maximum read wait cycles before an error response

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  2  per-requester request; held with its fields stable until accepted
- req_write  in  2  per-requester 1=write, 0=read
- req_addr  in  2*ADDR_BITS  requester i at [i*ADDR_BITS +: ADDR_BITS]
- req_wdata  in  2*DATA_BITS  requester i at [i*DATA_BITS +: DATA_BITS]
- req_ready  out  2  one-hot acceptance pulse; combinational
- resp_valid  out  1  one-cycle completion pulse; registered
- resp_id  out  1  requester index of the completed transaction
- resp_rdata  out  DATA_BITS  read data; 0 for writes and errors
- resp_err  out  1  read timed out
- tx_pins  out  IO_BITS  serial out; registered, 0 when idle
- rx_pins  in  IO_BITS  serial in; already registered at top level
- busy  out  1  state != IDLE

## Operation
- States: IDLE, HDR, ADDR, WDATA, WAIT, RDATA.
- IDLE:
  - If any `req_valid` bit is set, select a winner. With one requester valid, that one wins. With both valid, the winner is the requester that is not `last_grant`.
  - Assert `req_ready[winner]`, latch its write/addr/wdata into shift registers and id, set `last_grant` to the winner, and go to HDR.
- HDR: `tx_pins` = {1, write} with the MSB as start marker (IO_BITS=2), zero-padded for wider IO_BITS. Go to ADDR.
- ADDR: shift the address out LSB-first, one IO_BITS digit per cycle, for ADDR_BITS/IO_BITS cycles. Then go to WDATA if write, otherwise WAIT.
- WDATA: shift the write data out LSB-first for DATA_BITS/IO_BITS cycles. Then pulse `resp_valid` with `resp_err`=0 and `resp_rdata`=0, and go to IDLE.
- WAIT: `tx_pins`=0.
  - Each cycle, sample `rx_pins[0]`; when it is 1, go to RDATA.
  - If it is still 0 after TIMEOUT WAIT cycles, pulse `resp_valid` with `resp_err`=1 and `resp_rdata`=0, and go to IDLE.
- RDATA: shift in DATA_BITS/IO_BITS digits LSB-first, one per cycle. After the last digit, pulse `resp_valid` with the assembled data and `resp_err`=0, and go to IDLE.
- Reset values: state IDLE, `tx_pins`=0, `resp_valid`=0, `resp_id`=0, `resp_rdata`=0, `resp_err`=0, `busy`=0, `last_grant`=1, so requester 0 wins the first tie.
- Reset mid-transaction drops the transaction silently: no `resp_valid`, and `tx_pins` returns to 0 the next cycle.
- A requester deasserting `req_valid` before acceptance is legal; no grant results.
- `req_ready` is never asserted outside IDLE.

## Timing
- Cycle 0: accept in IDLE. Cycle 1: header. Cycles 2..1+A: address, with A=ADDR_BITS/IO_BITS (8 at defaults).
- Write, D=DATA_BITS/IO_BITS: data on cycles 2+A..1+A+D. `resp_valid` on cycle 2+A+D (18 at defaults).
- Read: WAIT starts at cycle 2+A. If the start digit is seen at cycle k, data digits are sampled at k+1..k+D and `resp_valid` fires at k+D+1.
- Timeout: WAIT cycles 2+A..1+A+TIMEOUT without a start digit give `resp_valid`/`resp_err` at cycle 2+A+TIMEOUT.
- The cycle carrying `resp_valid` is IDLE, so a new request may be accepted in that same cycle. Back-to-back throughput is 2+A+D cycles per write.
- The digit counter is $clog2(max(A,D)) bits and wraps to 0 at each phase change. The timeout counter is $clog2(TIMEOUT+1) bits.

## Structure
- Shared package `serial_bus_pkg`: state enum, header encoding constants (start bit position, write bit position), localparams for A and D.
- One sub-module: `bus_serdes`, a DATA_BITS-wide shift register with parallel load, digit shift-out, digit shift-in and parallel read. It is reused for the address and data phases; the address path uses a ADDR_BITS-wide instance.

## Test plan
- Requester 0 writes addr 0x1234, data 0xBEEF -> `req_ready`=01 at cycle 0. `tx_pins`: header 2'b11, then digits 0,1,3,0,2,0,1,0, then 3,3,2,3,2,3,3,2. `resp_valid` at cycle 18 with id 0 and err 0.
- Requester 1 reads addr 0x00FF; bench drives start at WAIT cycle 3, then digits for 0xA5C3 -> header 2'b10, `resp_rdata`=0xA5C3, `resp_id`=1, `resp_valid` 9 cycles after the start digit.
- Both requesters valid continuously, all writes -> grants alternate 0,1,0,1, starting with 0 after reset. Each accept coincides with the previous `resp_valid`.
- Read with `rx_pins` held 0 -> `resp_valid` with `resp_err`=1 and `resp_rdata`=0 exactly TIMEOUT cycles into WAIT (cycle 74 at defaults).
- Reset asserted during ADDR of a write -> `tx_pins`=0 and `busy`=0 the next cycle. No `resp_valid`. A pending requester 1 is then granted ahead of requester 0 only if requester 0 is idle.
